// File: rtl/chain_seq_if.sv
// chain_seq_if: controller handshake, config and chain-enable bundle for chain_sequencer
interface chain_seq_if #(
   parameter int NUM_LANES = 64,
   parameter int BURST_W   = 8,
   parameter int ROUND_W   = 8,
   parameter int CNT_W     = 32
);
   localparam int SEL_W = $clog2(NUM_LANES);
   logic                 start;
   logic                 abort;
   logic [NUM_LANES-1:0] lane_mask;
   logic [BURST_W-1:0]   burst_len;
   logic [ROUND_W-1:0]   rounds;
   logic [NUM_LANES-1:0] lane_en;
   logic [SEL_W-1:0]     lane_sel;
   logic                 busy;
   logic                 done;
   logic                 err_cfg;
   logic                 aborted;
   logic [CNT_W-1:0]     active_cycles;
   modport master (
      output start, abort, lane_mask, burst_len, rounds,
      input  lane_en, lane_sel, busy, done, err_cfg, aborted, active_cycles
   );
   modport slave (
      input  start, abort, lane_mask, burst_len, rounds,
      output lane_en, lane_sel, busy, done, err_cfg, aborted, active_cycles
   );
endinterface

// File: rtl/chain_sequencer.sv
// chain_sequencer: grants one chain at a time a burst of cycles, round-robin over a latched
// lane mask for a programmed number of rounds, with start/done handshake.
module chain_sequencer #(
   parameter int NUM_LANES = 64,
   parameter int BURST_W   = 8,
   parameter int ROUND_W   = 8,
   parameter int CNT_W     = 32
) (
   input logic        clk,
   input logic        rst_n,
   chain_seq_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_LANES);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t               state, state_nxt;
   logic [NUM_LANES-1:0] mask_q, above;
   logic [BURST_W-1:0]   blen_q, bcnt;
   logic [ROUND_W-1:0]   rnd_q, rcnt;
   logic [SEL_W-1:0]     sel, sel_lo, sel_up;
   logic [CNT_W-1:0]     act_cnt;
   logic                 err_q, abt_q, cfg_bad, last_beat, wrap, fin;

   function automatic logic [SEL_W-1:0] lowest(input logic [NUM_LANES-1:0] v);
      lowest = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) if (v[i]) lowest = SEL_W'(i);
   endfunction

   // Grant ends a lane when its burst runs out; an empty "above" set means a wrap.
   always_comb begin
      cfg_bad   = ~|bus.lane_mask || bus.burst_len == '0 || bus.rounds == '0;
      above     = mask_q & (({NUM_LANES{1'b1}} << sel) << 1);
      wrap      = ~|above;
      sel_lo    = lowest(mask_q);
      sel_up    = lowest(above);
      last_beat = state == RUN && bcnt == BURST_W'(1);
      fin       = last_beat && wrap && rcnt == ROUND_W'(1);
      state_nxt = state == IDLE ? (bus.start ? (cfg_bad ? DONE : LOAD) : IDLE)
                : state == DONE ? IDLE
                : (bus.abort || fin) ? DONE : RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q  <= '0;
         blen_q  <= '0;
         rnd_q   <= '0;
         bcnt    <= '0;
         rcnt    <= '0;
         sel     <= '0;
         act_cnt <= '0;
         err_q   <= 1'b0;
         abt_q   <= 1'b0;
      end else begin
         if (state == IDLE && bus.start) begin
            mask_q  <= bus.lane_mask;
            blen_q  <= bus.burst_len;
            rnd_q   <= bus.rounds;
            act_cnt <= '0;
            err_q   <= cfg_bad;
            abt_q   <= 1'b0;
         end
         if (state == LOAD) begin
            sel  <= sel_lo;
            bcnt <= blen_q;
            rcnt <= rnd_q;
         end
         if (state == RUN) begin
            bcnt    <= last_beat ? blen_q : bcnt - 1'b1;
            sel     <= last_beat ? (wrap ? sel_lo : sel_up) : sel;
            rcnt    <= (last_beat && wrap) ? rcnt - 1'b1 : rcnt;
            act_cnt <= &act_cnt ? act_cnt : act_cnt + 1'b1;
         end
         if ((state == LOAD || state == RUN) && bus.abort) abt_q <= 1'b1;
      end
   end

   assign bus.lane_en       = state == RUN ? {{(NUM_LANES-1){1'b0}}, 1'b1} << sel : '0;
   assign bus.lane_sel      = state == RUN ? sel : '0;
   assign bus.busy          = state == LOAD || state == RUN;
   assign bus.done          = state == DONE;
   assign bus.err_cfg       = state == DONE && err_q;
   assign bus.aborted       = state == DONE && abt_q;
   assign bus.active_cycles = act_cnt;
endmodule

// File: tb/tb_chain_sequencer.sv
// tb_chain_sequencer: randomized stimulus against a queue-based grant model, plus
// hand-computed checks of the documented scenarios.
module tb_chain_sequencer;
   localparam int NL = 64, BW = 8, RW = 8, CW = 32;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   chain_seq_if #(.NUM_LANES(NL), .BURST_W(BW), .ROUND_W(RW), .CNT_W(CW)) bus ();
   chain_sequencer #(.NUM_LANES(NL), .BURST_W(BW), .ROUND_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;

   int     n_vec = 0, n_err = 0;
   int     ph;
   int     q[$];
   bit     m_err, m_abt;
   longint m_act;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ph: 0 idle, 1 load cycle, 2 granting (q holds remaining grant lanes), 3 done pulse
   task automatic model_reset();
      ph = 0; q.delete(); m_err = 0; m_abt = 0; m_act = 0;
   endtask

   task automatic model_advance();
      case (ph)
         0: if (bus.start) begin
            m_act = 0; q.delete(); m_abt = 0;
            for (int r = 0; r < int'(bus.rounds); r++)
               for (int i = 0; i < NL; i++)
                  if (bus.lane_mask[i]) for (int b = 0; b < int'(bus.burst_len); b++) q.push_back(i);
            m_err = q.size() == 0;
            ph = m_err ? 3 : 1;
         end
         1: begin m_abt = bus.abort; ph = bus.abort ? 3 : 2; end
         2: begin
            if (m_act < 64'hFFFF_FFFF) m_act++;
            void'(q.pop_front());
            if (bus.abort) begin m_abt = 1; q.delete(); ph = 3; end
            else if (q.size() == 0) ph = 3;
         end
         default: ph = 0;
      endcase
   endtask

   always @(negedge clk) begin
      int lane;
      if (!rst_n) model_reset();
      lane = (ph == 2 && q.size() > 0) ? q[0] : 0;
      chk("lane_en", bus.lane_en, ph == 2 ? 64'(1) << lane : 64'd0);
      chk("lane_sel", 64'(bus.lane_sel), 64'(lane));
      chk("busy", 64'(bus.busy), 64'(ph == 1 || ph == 2));
      chk("done", 64'(bus.done), 64'(ph == 3));
      chk("err_cfg", 64'(bus.err_cfg), 64'(ph == 3 && m_err));
      chk("aborted", 64'(bus.aborted), 64'(ph == 3 && m_abt));
      chk("active_cycles", 64'(bus.active_cycles), 64'(m_act));
      if (rst_n) model_advance();
   end

   task automatic edges(input int n, input bit noise);
      repeat (n) begin
         @(posedge clk); #1;
         if (noise) begin
            bus.start     = 1'($urandom_range(0, 1));
            bus.lane_mask = {$urandom, $urandom};
            bus.burst_len = BW'($urandom);
         end
      end
   endtask

   task automatic go(input logic [NL-1:0] m, input int bl, input int rn);
      bus.lane_mask = m; bus.burst_len = BW'(bl); bus.rounds = RW'(rn); bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic t1(input bit noise);
      go(64'hA, 3, 2);
      edges(1, noise); chk("t1_lane_a", 64'(bus.lane_sel), 1); chk("t1_en_a", bus.lane_en, 64'h2);
      edges(3, noise); chk("t1_lane_b", 64'(bus.lane_sel), 3);
      edges(3, noise); chk("t1_lane_c", 64'(bus.lane_sel), 1);
      edges(3, noise); chk("t1_lane_d", 64'(bus.lane_sel), 3); chk("t1_en_d", bus.lane_en, 64'h8);
      edges(3, noise);
      chk("t1_done", 64'(bus.done), 1);
      chk("t1_active", 64'(bus.active_cycles), 12);
      chk("t1_err", 64'(bus.err_cfg), 0);
      chk("t1_abt", 64'(bus.aborted), 0);
      bus.start = 1'b0;
      edges(1, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 0; bus.abort = 0; bus.lane_mask = '0; bus.burst_len = '0; bus.rounds = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_en", bus.lane_en, 0);
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_done", 64'(bus.done), 0);
      rst_n = 1'b1;
      edges(1, 0);
      t1(0);
      go({1'b1, 63'd0}, 1, 1);
      edges(1, 0); chk("t2_sel", 64'(bus.lane_sel), 63); chk("t2_en", bus.lane_en, {1'b1, 63'd0});
      edges(1, 0); chk("t2_done", 64'(bus.done), 1);
      edges(1, 0);
      go(64'h0, 3, 2);
      chk("t3a_done", 64'(bus.done), 1); chk("t3a_err", 64'(bus.err_cfg), 1);
      edges(1, 0); chk("t3a_active", 64'(bus.active_cycles), 0);
      go(64'h5, 0, 2);
      chk("t3b_err", 64'(bus.err_cfg), 1); chk("t3b_en", bus.lane_en, 0);
      edges(1, 0);
      go(64'hF, 4, 1);
      edges(5, 0);
      bus.abort = 1'b1;
      edges(1, 0);
      chk("t4_en", bus.lane_en, 0); chk("t4_abt", 64'(bus.aborted), 1);
      chk("t4_active", 64'(bus.active_cycles), 5);
      edges(2, 0);
      bus.abort = 1'b0;
      t1(0);
      t1(1);
      go(64'hA, 3, 2);
      edges(3, 0);
      rst_n = 1'b0;
      #1;
      chk("t6_en", bus.lane_en, 0); chk("t6_busy", 64'(bus.busy), 0);
      chk("t6_active", 64'(bus.active_cycles), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      edges(1, 0);
      t1(0);
      for (int k = 0; k < 40; k++) begin
         logic [NL-1:0] m;
         int c;
         m = {$urandom, $urandom} & {$urandom, $urandom};
         if (k % 5 == 0) m = 64'(1) << $urandom_range(0, NL - 1);
         if (k % 7 == 3) m = '0;
         go(m, $urandom_range(0, 4), $urandom_range(0, 3));
         c = 0;
         while ((bus.busy || bus.done) && c < 2000) begin
            bus.abort = $urandom_range(0, 29) == 0;
            bus.start = 1'($urandom_range(0, 1));
            bus.lane_mask = {$urandom, $urandom};
            @(posedge clk); #1;
            c++;
         end
         chk("run_timeout", 64'(bus.busy), 0);
         bus.abort = 1'b0; bus.start = 1'b0;
         edges(1, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
